// File: rtl/alu_issue_seq_if.sv
// ---------------------------------------------------------------------------
// alu_issue_seq_if
//   Bundle of the request, ALU and response signals of alu_issue_seq.
//
//   Parameters
//     DEPTH  request FIFO entries (sets the width of fifo_count)
//     TAG_W  request tag width
//
//   Signal groups
//     req_*       request channel (valid/ready), operands, opcode, tag
//     alu_*       operand/opcode drive to the ALU and its result back
//     rsp_*       response channel (valid/ready), result, tag, error flag
//     busy        sequencer has work queued or in flight
//     fifo_count  request FIFO occupancy
//     rsp_zero    zero flag, present only when ZERO_FLAG_EN is defined
//
//   Modports
//     slave   sequencer side
//     master  environment side (request source, ALU, response sink)
// ---------------------------------------------------------------------------
interface alu_issue_seq_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [3:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_op;
  logic [31:0]      alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
`ifdef ZERO_FLAG_EN
  logic             rsp_zero;
`endif

  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_tag, rsp_err,
`ifdef ZERO_FLAG_EN
    output rsp_zero,
`endif
    output busy, fifo_count
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err,
`ifdef ZERO_FLAG_EN
    input  rsp_zero,
`endif
    input  busy, fifo_count
  );
endinterface

// File: rtl/alu_issue_seq.sv
// ---------------------------------------------------------------------------
// alu_issue_seq
//   Operand/opcode sequencer in front of the 32-bit 7-op ALU. Requests are
//   queued in a DEPTH-entry FIFO, issued one at a time with A/B/opcode held
//   for the ALU's registered-opcode timing, and the captured result is
//   returned with the request tag on a valid/ready response channel.
//   Illegal opcodes never reach the ALU; they produce an immediate error
//   response with data 0.
//
//   Ports
//     clk    clock, all logic on the rising edge
//     reset  synchronous active-low reset
//     bus    alu_issue_seq_if.slave (request, ALU drive, response, status)
//
//   Optional build macro
//     ZERO_FLAG_EN  adds bus.rsp_zero: result==0 for ALU ops, 1 for
//                   illegal-op responses. Undefined: no zero logic.
// ---------------------------------------------------------------------------
module alu_issue_seq #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_issue_seq_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 32 + 32 + 4 + TAG_W;
  localparam logic [3:0] OP_NOP = 4'b1111;

  // add, sub, slt, and, or, xor, nor
  localparam logic [6:0][3:0] LEGAL_OPS = {
    4'b0000, 4'b0010, 4'b1010, 4'b0100, 4'b0101, 4'b0110, 4'b0111
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_CAPT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
`ifdef ZERO_FLAG_EN
  logic             rsp_zero_q, rsp_zero_d;
`endif

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];

  logic             req_ready;
  logic             push;
  logic             pop;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [3:0]       head_op;
  logic [TAG_W-1:0] head_tag;
  logic [6:0]       op_hit;
  logic             head_legal;

  assign req_ready = (count_q < CNT_W'(DEPTH));
  assign push      = bus.req_valid && req_ready;
  // The head is only consumed from IDLE; RESP stalls never pop.
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  assign {head_a, head_b, head_op, head_tag} = fifo_mem[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_op_decode
      assign op_hit[gi] = (head_op == LEGAL_OPS[gi]);
    end
  endgenerate
  assign head_legal = |op_hit;

  // Storage needs no reset: stale entries are never read because the
  // occupancy count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.req_a, bus.req_b, bus.req_op, bus.req_tag};
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
`ifdef ZERO_FLAG_EN
    rsp_zero_d  = rsp_zero_q;
`endif

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          if (head_legal) begin
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            alu_op_d = head_op;
            tag_d    = head_tag;
            state_d  = S_ISSUE;
          end else begin
            // Rejected without touching the ALU drive registers.
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_tag_d   = head_tag;
            rsp_err_d   = 1'b1;
`ifdef ZERO_FLAG_EN
            rsp_zero_d  = 1'b1;
`endif
            state_d     = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        // The ALU registers the opcode on this edge; A/B stay put for HOLD.
        alu_op_d = OP_NOP;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.alu_result;
        rsp_tag_d   = tag_q;
        rsp_err_d   = 1'b0;
`ifdef ZERO_FLAG_EN
        rsp_zero_d  = (bus.alu_result == 32'b0);
`endif
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_NOP;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ZERO_FLAG_EN
      rsp_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ZERO_FLAG_EN
      rsp_zero_q  <= rsp_zero_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
`ifdef ZERO_FLAG_EN
  assign bus.rsp_zero   = rsp_zero_q;
`endif
  assign bus.busy       = (state_q != S_IDLE) || (count_q != '0);
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_seq
//   Self-checking bench for alu_issue_seq. Contains a model of the ALU
//   (opcode registered one edge, result registered the next) and a
//   reference queue of expected responses computed from each accepted
//   request. Build with +define+ZERO_FLAG_EN to cover rsp_zero.
// ---------------------------------------------------------------------------
module tb_alu_issue_seq;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [3:0] NOP = 4'b1111;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             zero;
  } rsp_t;

  logic clk;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  rsp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_issue_seq_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus();

  alu_issue_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected response for one request, straight from the opcode table.
  function automatic rsp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] tag);
    rsp_t r;
    r.tag = tag;
    r.err = 1'b0;
    case (op)
      4'b0000: r.data = a + b;
      4'b0010: r.data = a - b;
      4'b1010: r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: r.data = a & b;
      4'b0101: r.data = a | b;
      4'b0110: r.data = a ^ b;
      4'b0111: r.data = ~(a | b);
      default: begin r.data = 32'd0; r.err = 1'b1; end
    endcase
    r.zero = r.err ? 1'b1 : (r.data == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] alu_env(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    rsp_t m;
    m = model(op, a, b, '0);
    return m.err ? 32'hDEAD_BEEF : m.data;
  endfunction

  // ALU environment: opcode sampled on one edge, result registered the next.
  logic [3:0]  alu_op_s;
  logic [31:0] alu_res_r;
  always @(posedge clk) begin
    alu_op_s  <= bus.alu_op;
    alu_res_r <= alu_env(alu_op_s, bus.alu_a, bus.alu_b);
  end
  assign bus.alu_result = alu_res_r;

  function automatic logic [3:0] pick_op(input bit legal_only);
    logic [3:0] ops [10];
    ops = '{4'b0000, 4'b0010, 4'b1010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1111, 4'b0001, 4'b1100};
    return legal_only ? ops[$urandom_range(6, 0)] : ops[$urandom_range(9, 0)];
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom % 4)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
  endtask

  // Advance one clock; record any request accepted on this edge.
  task automatic tick();
    if (reset && bus.req_valid && bus.req_ready)
      exp_q.push_back(model(bus.req_op, bus.req_a, bus.req_b, bus.req_tag));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 4'd0, 32'd0, 32'd0, '0);
    tick();
    tick();
    vectors++; if (bus.fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    vectors++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    vectors++; if (bus.alu_op !== NOP) begin errors++; $display("FAIL reset_alu_op: got %b expected 1111", bus.alu_op); end
    vectors++; if ({bus.alu_a, bus.alu_b} !== 64'd0) begin errors++; $display("FAIL reset_alu_ab: got %h/%h expected 0/0", bus.alu_a, bus.alu_b); end
    vectors++; if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== '0) begin errors++; $display("FAIL reset_rsp: got data=%h tag=%0d err=%b expected all 0", bus.rsp_data, bus.rsp_tag, bus.rsp_err); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
`ifdef ZERO_FLAG_EN
    vectors++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", bus.rsp_zero); end
`endif
    reset = 1'b1;
    tick();
    $display("reset: flushed, outputs at reset values");
  endtask

  task automatic test_add();
    int lat;
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 4'b0000, 32'd5, 32'd7, TAG_W'(3));
    tick();
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin vectors++; if (bus.alu_op !== 4'b0000) begin errors++; $display("FAIL add_issue_op: got %b expected 0000", bus.alu_op); end end
      if (lat == 2) begin vectors++; if (bus.alu_op !== NOP) begin errors++; $display("FAIL add_hold_op: got %b expected 1111", bus.alu_op); end end
      if (lat >= 1 && lat <= 3) begin
        vectors++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin errors++; $display("FAIL add_ab_stable: got %0d/%0d expected 5/7 at cycle %0d", bus.alu_a, bus.alu_b, lat); end
      end
    end
    vectors++; if (lat != 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    vectors++; if (bus.rsp_data !== 32'd12 || bus.rsp_tag !== TAG_W'(3) || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL add_rsp: got data=%0d tag=%0d err=%b expected 12/3/0", bus.rsp_data, bus.rsp_tag, bus.rsp_err); end
    tick();
    vectors++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_release: got %b expected 0", bus.rsp_valid); end
    exp_q.delete();
    $display("add: 5+7 tag 3 -> %0d latency %0d", bus.rsp_data, lat);
  endtask

  task automatic test_backpressure();
    int g;
    bus.rsp_ready = 1'b0;
    set_req(1'b1, 4'b0010, 32'd10, 32'd3, TAG_W'(5));
    tick();
    bus.req_valid = 1'b0;
    g = 0;
    while (!bus.rsp_valid && g < 20) begin tick(); g++; end
    vectors++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_wait: got rsp_valid=%b expected 1", bus.rsp_valid); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd7 || bus.rsp_tag !== TAG_W'(5) || bus.rsp_err !== 1'b0)
        begin errors++; $display("FAIL bp_hold: got v=%b data=%0d tag=%0d err=%b expected 1/7/5/0 at stall %0d", bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_err, i); end
      vectors++;
      if (bus.fifo_count !== CNT_W'(i == 0 ? 0 : 1) || bus.alu_op !== NOP)
        begin errors++; $display("FAIL bp_no_pop: got count=%0d op=%b expected %0d/1111", bus.fifo_count, bus.alu_op, (i == 0 ? 0 : 1)); end
      if (i == 0) set_req(1'b1, 4'b0110, 32'h0000_00F0, 32'h0000_000F, TAG_W'(6));
      else bus.req_valid = 1'b0;
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    vectors++; if (bus.rsp_valid !== 1'b0 || bus.fifo_count !== CNT_W'(1)) begin errors++; $display("FAIL bp_complete: got v=%b count=%0d expected 0/1", bus.rsp_valid, bus.fifo_count); end
    tick();
    vectors++; if (bus.fifo_count !== '0 || bus.alu_op !== 4'b0110) begin errors++; $display("FAIL bp_next_pop: got count=%0d op=%b expected 0/0110", bus.fifo_count, bus.alu_op); end
    g = 0;
    while (!bus.rsp_valid && g < 20) begin tick(); g++; end
    vectors++; if (bus.rsp_data !== 32'h0000_00FF || bus.rsp_tag !== TAG_W'(6)) begin errors++; $display("FAIL bp_second: got data=%h tag=%0d expected 000000ff/6", bus.rsp_data, bus.rsp_tag); end
    tick();
    exp_q.delete();
    $display("backpressure: 10-3 held 6 stalled cycles, next op popped after release");
  endtask

  task automatic test_full();
    int g;
    int sent;
    bit acc;
    rsp_t e;
    bus.rsp_ready = 1'b0;
    sent = 0;
    g = 0;
    while (sent < 5 && g < 50) begin
      set_req(1'b1, pick_op(1'b1), rand_operand(), rand_operand(), TAG_W'(sent));
      acc = bus.req_ready;
      tick();
      if (acc) sent++;
      g++;
    end
    set_req(1'b1, pick_op(1'b1), rand_operand(), rand_operand(), TAG_W'(5));
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.fifo_count !== CNT_W'(DEPTH) || bus.req_ready !== 1'b0)
        begin errors++; $display("FAIL full_hold: got count=%0d req_ready=%b expected %0d/0", bus.fifo_count, bus.req_ready, DEPTH); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    g = 0;
    while ((exp_q.size() > 0 || bus.req_valid) && g < 200) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL full_unexpected: got tag %0d expected no response", bus.rsp_tag); end
        else begin
          e = exp_q.pop_front();
          if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err})
            begin errors++; $display("FAIL full_rsp: got data=%h tag=%0d err=%b expected %h/%0d/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err); end
          else $display("full: rsp tag %0d data %h", bus.rsp_tag, bus.rsp_data);
        end
      end
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (acc) bus.req_valid = 1'b0;
      g++;
    end
    vectors++; if (exp_q.size() != 0 || bus.req_valid) begin errors++; $display("FAIL full_drain: got %0d outstanding expected 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_illegal();
    logic [3:0]  ill [4];
    logic [31:0] a_prev;
    int          lat;
    ill = '{4'b1111, 4'b0001, 4'b1000, 4'b1011};
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_prev = bus.alu_a;
      set_req(1'b1, ill[k], $urandom, $urandom, TAG_W'(9 + k));
      tick();
      bus.req_valid = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 20) begin
        vectors++; if (bus.alu_op !== NOP) begin errors++; $display("FAIL ill_op_wait: got %b expected 1111", bus.alu_op); end
        tick();
        lat++;
      end
      vectors++; if (lat != 1) begin errors++; $display("FAIL ill_latency: got %0d expected 1", lat); end
      vectors++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'd0 || bus.rsp_tag !== TAG_W'(9 + k))
        begin errors++; $display("FAIL ill_rsp: got err=%b data=%h tag=%0d expected 1/0/%0d", bus.rsp_err, bus.rsp_data, bus.rsp_tag, 9 + k); end
      vectors++; if (bus.alu_op !== NOP || bus.alu_a !== a_prev) begin errors++; $display("FAIL ill_alu_untouched: got op=%b a=%h expected 1111/%h", bus.alu_op, bus.alu_a, a_prev); end
`ifdef ZERO_FLAG_EN
      vectors++; if (bus.rsp_zero !== 1'b1) begin errors++; $display("FAIL ill_zero: got %b expected 1", bus.rsp_zero); end
`endif
      tick();
      $display("illegal: op %b tag %0d -> err %b", ill[k], 9 + k, bus.rsp_err);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int   n;
    int   g;
    int   t_prev;
    rsp_t e;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, pick_op(1'b1), rand_operand(), rand_operand(), TAG_W'(i + 1));
      tick();
    end
    bus.req_valid = 1'b0;
    n = 0;
    g = 0;
    t_prev = 0;
    while (n < 3 && g < 60) begin
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        vectors++;
        if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err})
          begin errors++; $display("FAIL b2b_rsp: got data=%h tag=%0d err=%b expected %h/%0d/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err); end
        if (n > 0) begin
          vectors++; if (cyc - t_prev != 5) begin errors++; $display("FAIL b2b_spacing: got %0d expected 5", cyc - t_prev); end
        end
        $display("b2b: rsp tag %0d data %h at cycle %0d", bus.rsp_tag, bus.rsp_data, cyc);
        t_prev = cyc;
        n++;
      end
      tick();
      g++;
    end
    vectors++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 4'b0000, $urandom, $urandom, TAG_W'(12 + i));
      tick();
    end
    bus.req_valid = 1'b0;
    vectors++; if (bus.fifo_count !== CNT_W'(2) || bus.alu_op !== NOP || bus.rsp_valid !== 1'b0)
      begin errors++; $display("FAIL rmid_pre: got count=%0d op=%b v=%b expected 2/1111/0", bus.fifo_count, bus.alu_op, bus.rsp_valid); end
    reset = 1'b0;
    tick();
    vectors++; if (bus.fifo_count !== '0 || bus.rsp_valid !== 1'b0 || bus.alu_op !== NOP || bus.busy !== 1'b0)
      begin errors++; $display("FAIL rmid_flush: got count=%0d v=%b op=%b busy=%b expected 0/0/1111/0", bus.fifo_count, bus.rsp_valid, bus.alu_op, bus.busy); end
    vectors++; if ({bus.alu_a, bus.alu_b} !== 64'd0) begin errors++; $display("FAIL rmid_ab: got %h/%h expected 0/0", bus.alu_a, bus.alu_b); end
    reset = 1'b1;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) seen++;
      tick();
    end
    vectors++; if (seen != 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d responses expected 0", seen); end
    $display("reset_mid: flushed 2 queued ops + in-flight op, %0d responses after", seen);
  endtask

  task automatic test_random();
    int   g;
    rsp_t e;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 2 == 0) set_req(1'b1, pick_op(1'b0), rand_operand(), rand_operand(), TAG_W'($urandom));
      else bus.req_valid = 1'b0;
      bus.rsp_ready = ($urandom % 4) != 0;
      vectors++;
      if (bus.req_ready !== (bus.fifo_count < CNT_W'(DEPTH)))
        begin errors++; $display("FAIL rand_ready: got %b expected %b at count %0d", bus.req_ready, (bus.fifo_count < CNT_W'(DEPTH)), bus.fifo_count); end
      if (bus.rsp_valid && bus.rsp_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_unexpected: got tag %0d expected no response", bus.rsp_tag); end
        else begin
          e = exp_q.pop_front();
          if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err})
            begin errors++; $display("FAIL rand_rsp: got data=%h tag=%0d err=%b expected %h/%0d/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err); end
          else $display("rand: rsp tag %0d data %h err %b", bus.rsp_tag, bus.rsp_data, bus.rsp_err);
`ifdef ZERO_FLAG_EN
          vectors++; if (bus.rsp_zero !== e.zero) begin errors++; $display("FAIL rand_zero: got %b expected %b", bus.rsp_zero, e.zero); end
`endif
        end
      end
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        vectors++;
        if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err})
          begin errors++; $display("FAIL rand_drain: got data=%h tag=%0d err=%b expected %h/%0d/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err); end
      end
      tick();
      g++;
    end
    vectors++; if (exp_q.size() != 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rand_end: got %0d outstanding busy=%b expected 0/0", exp_q.size(), bus.busy); end
  endtask

`ifdef ZERO_FLAG_EN
  task automatic test_zero();
    int g;
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 4'b0010, 32'd9, 32'd9, TAG_W'(1));
    tick();
    bus.req_valid = 1'b0;
    g = 0;
    while (!bus.rsp_valid && g < 20) begin tick(); g++; end
    vectors++; if (bus.rsp_zero !== 1'b1 || bus.rsp_data !== 32'd0) begin errors++; $display("FAIL zero_sub: got zero=%b data=%h expected 1/0", bus.rsp_zero, bus.rsp_data); end
    tick();
    set_req(1'b1, 4'b0110, 32'd1, 32'd0, TAG_W'(2));
    tick();
    bus.req_valid = 1'b0;
    g = 0;
    while (!bus.rsp_valid && g < 20) begin tick(); g++; end
    vectors++; if (bus.rsp_zero !== 1'b0 || bus.rsp_data !== 32'd1) begin errors++; $display("FAIL zero_xor: got zero=%b data=%h expected 0/1", bus.rsp_zero, bus.rsp_data); end
    tick();
    exp_q.delete();
    $display("zero: 9-9 and 1^0 flags checked");
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_full();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
`ifdef ZERO_FLAG_EN
    test_zero();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
Upstream operand/opcode sequencer for the 32-bit 7-op ALU.
- Buffers requests in a small FIFO and drives the ALU's A/B/opcode inputs, holding them stable for the ALU's 2-cycle registered-opcode timing.
- Captures the ALU result and returns it, with the request tag, on a valid/ready response channel.
- One operation in flight at a time.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
TAG_W, 4, width of the request tag carried through to the response

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept (count < DEPTH)
req_a  in  32  operand A
req_b  in  32  operand B
req_op  in  4  ALU opcode
req_tag  in  TAG_W  request tag
alu_a  out  32  to ALU A (registered)
alu_b  out  32  to ALU B (registered)
alu_op  out  4  to ALU Opin (registered)
alu_result  in  32  from ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  downstream accepts response
rsp_data  out  32  captured result
rsp_tag  out  TAG_W  tag of completed request
rsp_err  out  1  request had an illegal opcode
busy  out  1  state != IDLE or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: clk is the single clock; reset is synchronous, active-low.
  - Sampled at the rising edge of clk when reset==0.
  - FIFO flushed, state=IDLE.
  - alu_a=alu_b=0, alu_op=4'b1111 (NOP).
  - rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, fifo_count=0.
  - Any in-flight op is discarded; no response is produced for it.
- Legal opcodes: 0000 add, 0010 sub, 1010 slt, 0100 and, 0101 or, 0110 xor, 0111 nor. All others are illegal.
- FIFO:
  - Push on req_valid&&req_ready.
  - req_ready = (fifo_count<DEPTH), combinational from count.
  - No push-through when full.
  - Pop only in IDLE when non-empty.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, HOLD, CAPT, RESP.
  - IDLE, FIFO non-empty: pop head.
    - Legal op: load alu_a/alu_b/alu_op and latch tag -> ISSUE.
    - Illegal op: rsp_data=0, rsp_err=1, rsp_tag=tag -> RESP. ALU regs untouched.
  - IDLE, FIFO empty: stay in IDLE.
  - ISSUE (ALU samples opcode): alu_op <= NOP at end of cycle; alu_a/alu_b held -> HOLD.
  - HOLD (ALU computes with held A/B) -> CAPT.
  - CAPT: rsp_data <= alu_result, rsp_err <= 0 -> RESP.
  - RESP: rsp_valid=1 and response outputs held stable until rsp_ready. Cycle with rsp_valid&&rsp_ready -> IDLE.
    - A pop may occur on the following cycle at the earliest.
- Latency:
  - Legal op: pop edge to rsp_valid high = 4 cycles.
  - Illegal op: 1 cycle.
  - Minimum occupancy per legal op is 5 cycles with rsp_ready tied high.
- alu_a/alu_b keep their last values outside ISSUE/HOLD; only alu_op returns to NOP.
- Requests complete strictly in FIFO order. Tags are not interpreted.
- Pushes continue normally during any state, including RESP stalls.

Optional Feature:
Macro ZERO_FLAG_EN.
- Defined:
  - Adds output port rsp_zero (1 bit, reset 0).
  - Set in CAPT to (alu_result==32'b0); set to 1 for illegal-op responses.
  - Valid and stable with rsp_valid.
- Undefined: port absent; no zero logic. All other behaviour is identical.

Test Plan:
1. Add: push a=5, b=7, op=0000, tag=3 with rsp_ready=1. Expect rsp_valid 4 cycles after pop with rsp_data=12, rsp_tag=3, rsp_err=0. alu_a/alu_b stable through ISSUE and HOLD.
2. Backpressure: sub a=10, b=3 with rsp_ready=0 for 6 cycles. Expect rsp_data=7 held stable with rsp_valid=1 all 6 cycles and no next pop. Completes the cycle after rsp_ready=1.
3. Full FIFO: DEPTH=4, rsp_ready=0, push 6 ops back-to-back. Expect req_ready=0 once fifo_count=4 after the first pop, and later pushes held off. Responses then return in push order with matching tags.
4. Illegal op: push op=4'b1111, tag=9. Expect rsp_valid 1 cycle after pop, rsp_err=1, rsp_data=0, rsp_tag=9, and alu_op never leaves NOP.
5. Reset mid-op: assert reset=0 during HOLD with 2 ops queued. Expect on the next edge fifo_count=0, rsp_valid=0, alu_op=1111, and no response ever emitted for the flushed ops.
6. ZERO_FLAG_EN: sub a=9, b=9 -> rsp_zero=1, rsp_data=0. Then xor a=1, b=0 -> rsp_zero=0, rsp_data=1.
